// File: rtl/uart_tx_param_if.sv
// CPU-side write port of the UART transmitter: write strobe/data in, FIFO status out.
interface uart_tx_param_if #(
  parameter int DATA_W     = 8,
  parameter int FIFO_DEPTH = 4
);
  logic                        wr_en;
  logic [DATA_W-1:0]           wr_data;
  logic                        full;
  logic                        empty;
  logic [$clog2(FIFO_DEPTH):0] level;
  logic                        ovf;

  modport master (output wr_en, wr_data, input full, empty, level, ovf);
  modport slave  (input wr_en, wr_data, output full, empty, level, ovf);
endinterface

// File: rtl/uart_tx_param.sv
// Parametrised UART transmitter with transmit FIFO: start bit, DATA_W data bits LSB-first,
// optional parity/ninth bit, 1 or 2 stop bits, bit timing from an oversampled tick enable.
module uart_tx_param #(
  parameter int DATA_W     = 8,
  parameter int OVERSAMPLE = 16,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                tick,
  input  logic [1:0]          cfg_parity,
  input  logic                cfg_bit9,
  input  logic                cfg_stop2,
  output logic                txd,
  output logic                busy,
  output logic                ti,
  uart_tx_param_if.slave      wr_if
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int LW = AW + 1;
  localparam int TW = $clog2(OVERSAMPLE);
  localparam int BW = $clog2(DATA_W);

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP1, STOP2} state_t;

  state_t            state;
  logic [DATA_W-1:0] mem [FIFO_DEPTH];
  logic [AW-1:0]     wr_ptr, rd_ptr;
  logic [LW-1:0]     count;
  logic              ovf_q;
  logic [DATA_W-1:0] shreg;
  logic [TW-1:0]     tick_cnt;
  logic [BW-1:0]     bit_cnt;
  logic              par_en, par_bit, stop2;

  logic              push, pop, bit_end, par_next;
  logic [DATA_W-1:0] head;

  assign wr_if.full  = (count == LW'(FIFO_DEPTH));
  assign wr_if.empty = (count == '0);
  assign wr_if.level = count;
  assign wr_if.ovf   = ovf_q;

  // full is taken from the registered count, so a same-cycle pop never admits a write
  assign push    = wr_if.wr_en && !wr_if.full;
  assign pop     = (state == IDLE) && !wr_if.empty;
  assign head    = mem[rd_ptr];
  assign bit_end = tick && (tick_cnt == TW'(OVERSAMPLE - 1));

  always_comb begin
    par_next = 1'b0;
    case (cfg_parity)
      2'b01:   par_next = ^head;
      2'b10:   par_next = ~^head;
      2'b11:   par_next = cfg_bit9;
      default: par_next = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= wr_if.wr_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      ovf_q  <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      count <= count + LW'(push) - LW'(pop);
      ovf_q <= wr_if.wr_en && wr_if.full;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      txd      <= 1'b1;
      busy     <= 1'b0;
      ti       <= 1'b0;
      shreg    <= '0;
      tick_cnt <= '0;
      bit_cnt  <= '0;
      par_en   <= 1'b0;
      par_bit  <= 1'b0;
      stop2    <= 1'b0;
    end else begin
      ti <= 1'b0;
      if (state != IDLE && tick)
        tick_cnt <= bit_end ? '0 : tick_cnt + 1'b1;
      // txd is registered, so each transition loads the level of the bit being entered
      case (state)
        IDLE: begin
          txd <= 1'b1;
          if (pop) begin
            shreg    <= head;
            par_en   <= (cfg_parity != 2'b00);
            par_bit  <= par_next;
            stop2    <= cfg_stop2;
            tick_cnt <= '0;
            bit_cnt  <= '0;
            state    <= START;
            txd      <= 1'b0;
            busy     <= 1'b1;
          end
        end
        START: if (bit_end) begin
          state <= DATA;
          txd   <= shreg[0];
        end
        DATA: if (bit_end) begin
          shreg   <= shreg >> 1;
          bit_cnt <= bit_cnt + 1'b1;
          if (bit_cnt == BW'(DATA_W - 1)) begin
            state <= par_en ? PARITY : STOP1;
            txd   <= par_en ? par_bit : 1'b1;
          end else begin
            txd <= shreg[1];
          end
        end
        PARITY: if (bit_end) begin
          state <= STOP1;
          txd   <= 1'b1;
        end
        STOP1: if (bit_end) begin
          if (stop2) begin
            state <= STOP2;
          end else begin
            state <= IDLE;
            busy  <= 1'b0;
            ti    <= 1'b1;
          end
        end
        STOP2: if (bit_end) begin
          state <= IDLE;
          busy  <= 1'b0;
          ti    <= 1'b1;
        end
        default: begin
          state <= IDLE;
          txd   <= 1'b1;
          busy  <= 1'b0;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_uart_tx_param.sv
// Bench for uart_tx_param: frame-level reference model compared every cycle, plus
// hand-computed frames, FIFO overflow, asynchronous reset and a DATA_W=9 instance.
module tb_uart_tx_param;
  logic       clk = 1'b0;
  logic       rst_n;
  logic       tick, cfg_bit9, cfg_stop2;
  logic [1:0] cfg_parity;
  logic       txd, busy, ti;
  logic       wr_en;
  logic [7:0] wr_data;

  logic       tick2, txd2, busy2, ti2, wr_en2;
  logic [8:0] wr_data2;

  int n_cmp = 0;
  int n_bad = 0;
  bit chk_en = 1'b0;

  always #5 clk = ~clk;

  uart_tx_param_if #(.DATA_W(8), .FIFO_DEPTH(4)) bus ();
  uart_tx_param_if #(.DATA_W(9), .FIFO_DEPTH(2)) bus2 ();
  assign bus.wr_en    = wr_en;
  assign bus.wr_data  = wr_data;
  assign bus2.wr_en   = wr_en2;
  assign bus2.wr_data = wr_data2;

  uart_tx_param #(.DATA_W(8), .OVERSAMPLE(16), .FIFO_DEPTH(4)) dut (
    .clk(clk), .rst_n(rst_n), .tick(tick), .cfg_parity(cfg_parity), .cfg_bit9(cfg_bit9),
    .cfg_stop2(cfg_stop2), .txd(txd), .busy(busy), .ti(ti), .wr_if(bus));

  uart_tx_param #(.DATA_W(9), .OVERSAMPLE(4), .FIFO_DEPTH(2)) dut9 (
    .clk(clk), .rst_n(rst_n), .tick(tick2), .cfg_parity(2'b00), .cfg_bit9(1'b0),
    .cfg_stop2(1'b0), .txd(txd2), .busy(busy2), .ti(ti2), .wr_if(bus2));

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: a word queue and the current frame as a plain list of serial bits.
  byte unsigned m_q[$];
  bit [15:0]    m_bits;
  int           m_len, m_idx, m_tc;
  bit           m_active;
  bit           e_txd = 1'b1, e_busy = 1'b0, e_ti = 1'b0, e_ovf = 1'b0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_q.delete();
      m_active = 1'b0; m_idx = 0; m_tc = 0; m_len = 0;
      e_txd = 1'b1; e_busy = 1'b0; e_ti = 1'b0; e_ovf = 1'b0;
    end else begin
      bit          full_now, was_idle;
      byte unsigned w;
      full_now = (m_q.size() == 4);
      was_idle = !m_active;
      e_ti  = 1'b0;
      e_ovf = wr_en && full_now;
      if (m_active && tick) begin
        m_tc++;
        if (m_tc == 16) begin
          m_tc = 0;
          m_idx++;
          if (m_idx == m_len) begin
            m_active = 1'b0;
            e_ti = 1'b1;
          end
        end
      end
      if (was_idle && m_q.size() != 0) begin
        w = m_q.pop_front();
        m_bits = '0;
        m_bits[0] = 1'b0;
        for (int i = 0; i < 8; i++) m_bits[1+i] = w[i];
        m_len = 9;
        if (cfg_parity != 2'b00) begin
          m_bits[m_len] = (cfg_parity == 2'b01) ? ^w : (cfg_parity == 2'b10) ? ~^w : cfg_bit9;
          m_len++;
        end
        m_bits[m_len] = 1'b1; m_len++;
        if (cfg_stop2) begin m_bits[m_len] = 1'b1; m_len++; end
        m_active = 1'b1; m_idx = 0; m_tc = 0;
      end
      if (wr_en && !full_now) m_q.push_back(wr_data);
      e_txd  = m_active ? m_bits[m_idx] : 1'b1;
      e_busy = m_active;
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      check("txd",   32'(txd),        32'(e_txd));
      check("busy",  32'(busy),       32'(e_busy));
      check("ti",    32'(ti),         32'(e_ti));
      check("ovf",   32'(bus.ovf),    32'(e_ovf));
      check("level", 32'(bus.level),  32'(m_q.size()));
      check("full",  32'(bus.full),   32'(m_q.size() == 4));
      check("empty", 32'(bus.empty),  32'(m_q.size() == 0));
    end
  end

  // Writes one word to an idle transmitter and checks a hand-computed bit pattern,
  // busy length and ti position (cycle 1 is the first negedge after the write edge).
  task automatic frame_lit(input bit sel, input logic [8:0] w, input logic [15:0] exp_bits,
                           input int nbits, input int os, input bit flip);
    int busy_cnt = 0, ti_cnt = 0, ti_cyc = 0;
    logic t, b, p;
    @(negedge clk);
    if (sel) begin wr_en2 = 1'b1; wr_data2 = w; end
    else     begin wr_en  = 1'b1; wr_data  = w[7:0]; end
    @(negedge clk);
    wr_en = 1'b0; wr_en2 = 1'b0;
    for (int cyc = 1; cyc <= os * nbits + 8; cyc++) begin
      t = sel ? txd2  : txd;
      b = sel ? busy2 : busy;
      p = sel ? ti2   : ti;
      if (b) busy_cnt++;
      if (p) begin ti_cnt++; ti_cyc = cyc; end
      for (int k = 0; k < nbits; k++)
        if (cyc == 2 + os * k + os / 2) check($sformatf("bit%0d", k), 32'(t), 32'(exp_bits[k]));
      if (flip && cyc == 50) cfg_stop2 = ~cfg_stop2;
      @(negedge clk);
    end
    check("busy_len", busy_cnt, os * nbits);
    check("ti_count", ti_cnt, 1);
    check("ti_cycle", ti_cyc, os * nbits + 2);
  endtask

  task automatic drain();
    int i = 0;
    tick = 1'b1; wr_en = 1'b0;
    while ((e_busy || m_q.size() != 0) && i < 3000) begin
      @(negedge clk);
      i++;
    end
    repeat (2) @(negedge clk);
    check("drain_busy",  32'(busy),      32'd0);
    check("drain_empty", 32'(bus.empty), 32'd1);
  endtask

  initial begin
    int  ti_cnt;
    bit  ovf_seen;
    rst_n = 1'b0; tick = 1'b0; tick2 = 1'b1; wr_en = 1'b0; wr_data = '0;
    wr_en2 = 1'b0; wr_data2 = '0; cfg_parity = 2'b00; cfg_bit9 = 1'b0; cfg_stop2 = 1'b0;
    #23;
    check("rst_txd",   32'(txd),       32'd1);
    check("rst_busy",  32'(busy),      32'd0);
    check("rst_ti",    32'(ti),        32'd0);
    check("rst_full",  32'(bus.full),  32'd0);
    check("rst_empty", 32'(bus.empty), 32'd1);
    check("rst_level", 32'(bus.level), 32'd0);
    check("rst_ovf",   32'(bus.ovf),   32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    chk_en = 1'b1;
    tick = 1'b1;

    frame_lit(1'b1, 9'h1A5, 16'h074A, 11, 4, 1'b0);
    check("i9_empty", 32'(bus2.empty), 32'd1);
    check("i9_full",  32'(bus2.full),  32'd0);
    check("i9_ovf",   32'(bus2.ovf),   32'd0);
    check("i9_level", 32'(bus2.level), 32'd0);

    frame_lit(1'b0, 9'h055, 16'h02AA, 10, 16, 1'b0);
    cfg_parity = 2'b01; frame_lit(1'b0, 9'h007, 16'h060E, 11, 16, 1'b0);
    cfg_parity = 2'b10; frame_lit(1'b0, 9'h007, 16'h040E, 11, 16, 1'b0);
    cfg_parity = 2'b11; cfg_bit9 = 1'b1; frame_lit(1'b0, 9'h007, 16'h060E, 11, 16, 1'b0);
    cfg_parity = 2'b00; cfg_bit9 = 1'b0; cfg_stop2 = 1'b1;
    frame_lit(1'b0, 9'h0FF, 16'h07FE, 11, 16, 1'b1);
    cfg_stop2 = 1'b0;
    drain();

    // FIFO fill with the transmitter held off
    tick = 1'b0; ovf_seen = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      ovf_seen |= bus.ovf;
      wr_en = 1'b1; wr_data = 8'(8'h11 * (i + 1));
    end
    @(negedge clk);
    wr_en = 1'b0;
    ovf_seen |= bus.ovf;
    check("fifo_level4", 32'(bus.level), 32'd4);
    check("fifo_full",   32'(bus.full),  32'd1);
    check("fifo_no_ovf", 32'(ovf_seen),  32'd0);
    wr_en = 1'b1; wr_data = 8'h66;
    @(negedge clk);
    wr_en = 1'b0;
    check("ovf_pulse",   32'(bus.ovf),   32'd1);
    check("ovf_level",   32'(bus.level), 32'd4);
    @(negedge clk);
    check("ovf_single",  32'(bus.ovf),   32'd0);
    tick = 1'b1; ti_cnt = 0;
    for (int i = 0; i < 5 * 170 && ti_cnt < 5; i++) begin
      @(negedge clk);
      if (ti) ti_cnt++;
    end
    check("fifo_ti5", ti_cnt, 5);
    drain();

    // Asynchronous reset in the middle of data bit 3, with a second word queued
    @(negedge clk); wr_en = 1'b1; wr_data = 8'hA5;
    @(negedge clk); wr_data = 8'h3C;
    @(negedge clk); wr_en = 1'b0;
    repeat (70) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("arst_txd",   32'(txd),       32'd1);
    check("arst_busy",  32'(busy),      32'd0);
    check("arst_level", 32'(bus.level), 32'd0);
    check("arst_ti",    32'(ti),        32'd0);
    @(negedge clk);
    #2 rst_n = 1'b1;
    frame_lit(1'b0, 9'h0A5, 16'h034A, 10, 16, 1'b0);

    // Randomized traffic: bursty writes first, then sparse, with config changing freely
    for (int c = 0; c < 4000; c++) begin
      @(negedge clk);
      wr_en      = (c < 600) ? ($urandom_range(0, 1) == 0) : ($urandom_range(0, 15) == 0);
      wr_data    = 8'($urandom);
      tick       = ($urandom_range(0, 3) != 0);
      cfg_parity = 2'($urandom);
      cfg_bit9   = 1'($urandom);
      cfg_stop2  = 1'($urandom);
    end
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #3000000;
    $display("FAIL timeout: simulation did not finish, compared %0d", n_cmp);
    $fatal(1, "timeout");
  end
endmodule
